// File: rtl/cpu_mem_pkg.sv
// Shared constants and state encoding for the CPU memory responder.
package cpu_mem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PROG_START = 8;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

endpackage

// File: rtl/mem_array_sp.sv
// Single write port / single read-first registered read port word array.
module mem_array_sp #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Non-blocking read of the same array gives read-first behaviour on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: clear sweep after reset, CPU read/write, preload port.
// Optional CPU write protection below PROG_START via macro CPU_MEM_WP_EN.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PROG_START = DEF_PROG_START
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] mem,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  busy,
`ifdef CPU_MEM_WP_EN
  output logic                  wp_err,
`endif
  output logic [ADDR_WIDTH-1:0] ld_base
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PROG_A  = ADDR_WIDTH'(PROG_START);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_busy;

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_rd_en;
  logic                  w_ld_ready;
  logic                  w_wp_hit;

`ifdef CPU_MEM_WP_EN
  logic                  r_wp_err;
  assign w_wp_hit = we && (addr < PROG_A);
`else
  assign w_wp_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_CLEAR);
    end
  end

  // Write port arbitration: sweep, then CPU write, then preload.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_cnt;
    w_wr_data   = '0;
    w_rd_en     = 1'b0;
    w_ld_ready  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_A) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_rd_en    = 1'b1;
        w_ld_ready = !we;
        if (we) begin
          w_wr_en   = !w_wp_hit;
          w_wr_addr = addr;
          w_wr_data = data;
        end else if (ld_valid) begin
          w_wr_en   = 1'b1;
          w_wr_addr = ld_addr;
          w_wr_data = ld_data;
        end
      end
    endcase
  end

`ifdef CPU_MEM_WP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp_err <= 1'b0;
    end else if ((r_state == S_RUN) && w_wp_hit) begin
      r_wp_err <= 1'b1;
    end
  end

  assign wp_err = r_wp_err;
`endif

  mem_array_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (addr),
    .o_rd_data (mem)
  );

  assign ld_ready = w_ld_ready;
  assign busy     = r_busy;
  assign ld_base  = PROG_A;

endmodule
